// File: rtl/aes_types_pkg.sv
// Shared AES datapath word types.
package aes_types_pkg;
    typedef logic [127:0] ulogic128;
    typedef logic [31:0]  ulogic32;
endpackage

// File: rtl/aes_block_unloader.sv
// AES output unloader: buffers 128-bit result blocks and streams each block
// to the host side as four 32-bit words over a valid/ready handshake.
module aes_block_unloader
    import aes_types_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter bit MSW_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  ulogic128    blk_data_in,
    input  logic        blk_valid_in,
    output logic        blk_ready_out,
    output ulogic32     word_data_out,
    output logic        word_valid_out,
    input  logic        word_ready_in,
    output logic        word_last_out,
    output logic [1:0]  word_idx_out,
    output logic        busy_out,
    output logic [15:0] blk_count_out
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic {ST_EMPTY, ST_STREAM} state_t;

    state_t           state_q, state_d;
    ulogic128         buf_q [BUF_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             acc, xfer, pop;
    ulogic128         head_blk;
    ulogic32          word_sel;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Block storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (acc) begin
            buf_q[tail_q] <= blk_data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        // Accept uses the registered ready, so a pop in the same cycle cannot free a slot early.
        acc     = blk_valid_in & ready_q;
        xfer    = (state_q == ST_STREAM) & word_ready_in;
        pop     = xfer & (idx_q == 2'd3);

        if (xfer) begin
            idx_d = idx_q + 2'd1;
        end
        if (pop) begin
            head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
            cnt_d  = cnt_q + 16'd1;
        end
        if (acc) begin
            tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
        end

        case ({acc, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        ready_d = (occ_d < OCC_FULL);
        state_d = (occ_d != '0) ? ST_STREAM : ST_EMPTY;
    end

    always_comb begin
        head_blk = buf_q[head_q];
        case (idx_q)
            2'd0:    word_sel = MSW_FIRST ? head_blk[127:96] : head_blk[31:0];
            2'd1:    word_sel = MSW_FIRST ? head_blk[95:64]  : head_blk[63:32];
            2'd2:    word_sel = MSW_FIRST ? head_blk[63:32]  : head_blk[95:64];
            default: word_sel = MSW_FIRST ? head_blk[31:0]   : head_blk[127:96];
        endcase
    end

    assign word_valid_out = (state_q == ST_STREAM);
    assign word_data_out  = word_valid_out ? word_sel : '0;
    assign word_idx_out   = idx_q;
    assign word_last_out  = word_valid_out & (idx_q == 2'd3);
    assign blk_ready_out  = ready_q;
    assign busy_out       = (occ_q != '0);
    assign blk_count_out  = cnt_q;

endmodule
